// File: rtl/sort_pkg.sv
// Shared definitions for the sort output path: default geometry, the signed
// element type and the parallel-in/serial-out streamer state encoding.
package sort_pkg;

    localparam int WIDTH_DEF = 6;
    localparam int DEPTH_DEF = 8;
    localparam int IDX_W     = $clog2(DEPTH_DEF);

    typedef logic signed [WIDTH_DEF-1:0] elem_t;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } piso_state_t;

endpackage

// File: rtl/sort_order_chk.sv
// Watches the serial stream of sorted_piso and raises a sticky flag when an
// element is larger (signed) than the element accepted just before it within
// the same vector. Only built when SORTED_PISO_ORDER_CHECK_EN is defined.
module sort_order_chk
    import sort_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             beat,
    input  logic             first,
    input  logic [WIDTH-1:0] data,
    output logic             err
);

    logic signed [WIDTH-1:0] prev;
    logic signed [WIDTH-1:0] cur;
    logic                    rising;

    assign cur    = data;
    assign rising = beat & ~first & (cur > prev);

    // Remember the most recently accepted element for the next comparison.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev <= '0;
        end else if (beat) begin
            prev <= cur;
        end
    end

    // Sticky violation flag; a fresh load starts a clean vector.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err <= 1'b0;
        end else if (clear) begin
            err <= 1'b0;
        end else if (rising) begin
            err <= 1'b1;
        end
    end

endmodule

// File: rtl/sorted_piso.sv
// sorted_piso: captures a full sorted vector from the merge sorter in one
// cycle and streams it out one element per accepted valid/ready beat,
// element 0 (largest) first.
// Optional ordering monitor: define SORTED_PISO_ORDER_CHECK_EN to build it;
// otherwise order_err is tied low.
module sorted_piso
    import sort_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load_valid,
    output logic                     load_ready,
    input  logic [WIDTH*DEPTH-1:0]   load_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [$clog2(DEPTH)-1:0] out_index,
    output logic                     out_last,
    output logic                     busy,
    output logic                     order_err
);

    localparam int              IW       = $clog2(DEPTH);
    localparam int              VW       = WIDTH * DEPTH;
    localparam logic [IW-1:0]   LAST_IDX = IW'(DEPTH - 1);

    piso_state_t     state;
    piso_state_t     state_next;
    logic [VW-1:0]   shreg;
    logic [IW-1:0]   idx;
    logic            at_last;
    logic            load_fire;
    logic            beat;

    assign at_last   = (idx == LAST_IDX);
    assign load_fire = (state == IDLE) & load_valid;
    assign beat      = (state == STREAM) & out_ready;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs, decoded from the current state only.
    always_comb begin
        state_next = state;
        load_ready = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                load_ready = rst;
                if (load_valid) begin
                    state_next = STREAM;
                end
            end
            STREAM: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                if (out_ready && at_last) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Shift register and element index: load whole vector, then shift one
    // word out of the top per accepted beat with zero fill from below.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg <= '0;
            idx   <= '0;
        end else if (load_fire) begin
            shreg <= load_data;
            idx   <= '0;
        end else if (beat) begin
            shreg <= {shreg[VW-WIDTH-1:0], {WIDTH{1'b0}}};
            idx   <= at_last ? '0 : idx + 1'b1;
        end
    end

    assign out_data  = shreg[VW-1 -: WIDTH];
    assign out_index = idx;
    assign out_last  = (state == STREAM) & at_last;

`ifdef SORTED_PISO_ORDER_CHECK_EN
    logic first_beat;

    assign first_beat = (idx == '0);

    sort_order_chk #(
        .WIDTH (WIDTH)
    ) u_order_chk (
        .clk   (clk),
        .rst   (rst),
        .clear (load_fire),
        .beat  (beat),
        .first (first_beat),
        .data  (out_data),
        .err   (order_err)
    );
`else
    assign order_err = 1'b0;
`endif

endmodule

// File: tb/tb_sorted_piso.sv
// Scoreboard testbench for sorted_piso. A queue holds the elements the block
// still owes; it is filled from the vector whenever a load is taken and
// drained on every accepted beat. A negedge monitor compares the presented
// element and the handshake outputs against the queue head.
module tb_sorted_piso;

`ifdef SORTED_PISO_ORDER_CHECK_EN
    localparam bit ORDER_EN = 1'b1;
`else
    localparam bit ORDER_EN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        load_valid;
    logic        load_ready;
    logic [47:0] load_data;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  out_data;
    logic [2:0]  out_index;
    logic        out_last;
    logic        busy;
    logic        order_err;

    typedef struct {
        logic [5:0] data;
        int         idx;
    } exp_t;

    exp_t       exp_q[$];
    int         n_checks;
    int         n_fail;
    int         beats;
    int         idle_cnt;
    int         rdy_mode;
    int         rdy_cnt;
    bit         model_err;
    logic [5:0] model_prev;

    sorted_piso dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_index  (out_index),
        .out_last   (out_last),
        .busy       (busy),
        .order_err  (order_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [47:0] actual,
                                input logic [47:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic report_timeout(input string name);
        n_checks++;
        n_fail++;
        $display("[TB] FAIL %s: timed out waiting, expected completion at %0t", name, $time);
    endtask

    function automatic logic [47:0] pack8(input logic [5:0] e [8]);
        logic [47:0] v;
        for (int i = 0; i < 8; i++) v[47-6*i -: 6] = e[i];
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a vector and hold it until the block takes it.
    task automatic apply_stimulus(input logic [47:0] vec, input bit hold);
        bit taken;
        taken      = 1'b0;
        load_valid = 1'b1;
        load_data  = vec;
        for (int n = 0; n < 200 && !taken; n++) begin
            if (load_ready) taken = 1'b1;
            tick();
        end
        if (!taken) report_timeout("load_accept");
        if (!hold) load_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int n = 0; n < 300 && !done; n++) begin
            if (!out_valid) done = 1'b1;
            else tick();
        end
        if (!done) report_timeout("drain");
    endtask

    // out_ready pattern generator: always, 1-0-0 repeating, or random.
    always @(posedge clk) begin
        #1;
        rdy_cnt++;
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = (rdy_cnt % 3 == 0);
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Reference model: block owes nothing -> it takes a load; otherwise each
    // ready cycle consumes the next owed element.
    always @(posedge clk or negedge rst) begin : model
        exp_t e;
        if (!rst) begin
            exp_q.delete();
            model_err  = 1'b0;
            model_prev = '0;
        end else if (exp_q.size() != 0) begin
            if (out_ready) begin
                e = exp_q.pop_front();
                beats++;
                if (ORDER_EN && e.idx > 0 && $signed(e.data) > $signed(model_prev))
                    model_err = 1'b1;
                model_prev = e.data;
            end
        end else if (load_valid) begin
            for (int i = 0; i < 8; i++) begin
                e.data = load_data[47-6*i -: 6];
                e.idx  = i;
                exp_q.push_back(e);
            end
            model_err = 1'b0;
        end
    end

    // Monitor: compare presented outputs with what the model still owes.
    always @(negedge clk) begin : monitor
        bit has;
        if (rst === 1'b1) begin
            has = (exp_q.size() != 0);
            check_output("out_valid", 48'(out_valid), 48'(has));
            check_output("load_ready", 48'(load_ready), 48'(!has));
            check_output("busy", 48'(busy), 48'(has));
            check_output("order_err", 48'(order_err), 48'(model_err));
            if (has) begin
                check_output("out_data", 48'(out_data), 48'(exp_q[0].data));
                check_output("out_index", 48'(out_index), 48'(exp_q[0].idx));
                check_output("out_last", 48'(out_last), 48'(exp_q[0].idx == 7));
            end
            if (!out_valid) idle_cnt++;
        end
    end

    initial begin : watchdog
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected end by %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stim
        logic [5:0]  e [8];
        logic [47:0] v_basic;
        logic [47:0] v_five;
        logic [47:0] v_tenth;
        logic [47:0] v_bad;
        logic [5:0]  t;
        int          b0;
        int          i0;

        n_checks   = 0;
        n_fail     = 0;
        beats      = 0;
        idle_cnt   = 0;
        rdy_mode   = 0;
        rdy_cnt    = 0;
        out_ready  = 1'b0;
        load_valid = 1'b0;
        load_data  = '0;
        rst        = 1'b0;

        e = '{6'h1F, 6'h14, 6'h07, 6'h00, 6'h3F, 6'h3B, 6'h2C, 6'h20};
        v_basic = pack8(e);
        e = '{6'h05, 6'h05, 6'h05, 6'h05, 6'h05, 6'h05, 6'h05, 6'h05};
        v_five = pack8(e);
        e = '{6'h0A, 6'h09, 6'h08, 6'h07, 6'h06, 6'h05, 6'h04, 6'h03};
        v_tenth = pack8(e);
        e = '{6'h0A, 6'h0C, 6'h08, 6'h07, 6'h06, 6'h05, 6'h04, 6'h03};
        v_bad = pack8(e);

        // Reset state
        #12;
        check_output("rst_out_valid", 48'(out_valid), 48'd0);
        check_output("rst_out_data", 48'(out_data), 48'd0);
        check_output("rst_busy", 48'(busy), 48'd0);
        check_output("rst_order_err", 48'(order_err), 48'd0);
        @(negedge clk);
        #2 rst = 1'b1;
        tick();
        check_output("idle_load_ready", 48'(load_ready), 48'd1);

        // Basic drain
        $display("[TB] basic drain");
        rdy_mode = 0;
        apply_stimulus(v_basic, 1'b0);
        check_output("basic_first_data", 48'(out_data), 48'h1F);
        check_output("basic_first_index", 48'(out_index), 48'd0);
        wait_idle();

        // Backpressure
        $display("[TB] backpressure");
        rdy_mode = 1;
        b0 = beats;
        apply_stimulus(v_basic, 1'b0);
        wait_idle();
        check_output("bp_handshakes", 48'(beats - b0), 48'd8);

        // Load while busy
        $display("[TB] load while busy");
        rdy_mode = 0;
        b0 = beats;
        apply_stimulus(v_basic, 1'b0);
        tick();
        tick();
        apply_stimulus(v_five, 1'b0);
        check_output("lwb_second_data", 48'(out_data), 48'h05);
        wait_idle();
        check_output("lwb_handshakes", 48'(beats - b0), 48'd16);

        // Mid-stream reset after three accepted beats
        $display("[TB] mid-stream reset");
        rdy_mode = 0;
        apply_stimulus(v_basic, 1'b0);
        tick();
        tick();
        tick();
        check_output("pre_rst_index", 48'(out_index), 48'd3);
        #2 rst = 1'b0;
        #1;
        check_output("mrst_out_valid", 48'(out_valid), 48'd0);
        check_output("mrst_out_data", 48'(out_data), 48'd0);
        check_output("mrst_out_index", 48'(out_index), 48'd0);
        check_output("mrst_out_last", 48'(out_last), 48'd0);
        check_output("mrst_busy", 48'(busy), 48'd0);
        check_output("mrst_load_ready", 48'(load_ready), 48'd0);
        @(negedge clk);
        #2 rst = 1'b1;
        tick();
        apply_stimulus(v_tenth, 1'b0);
        check_output("after_rst_data", 48'(out_data), 48'h0A);
        check_output("after_rst_index", 48'(out_index), 48'd0);
        wait_idle();

        // Ordering monitor
        $display("[TB] order check");
        apply_stimulus(v_bad, 1'b0);
        wait_idle();
        check_output("order_err_sticky", 48'(order_err), 48'(ORDER_EN));
        apply_stimulus(v_tenth, 1'b0);
        check_output("order_err_cleared", 48'(order_err), 48'd0);
        wait_idle();

        // Back-to-back with load_valid held
        $display("[TB] back-to-back");
        apply_stimulus(v_basic, 1'b1);
        i0 = idle_cnt;
        apply_stimulus(v_five, 1'b1);
        apply_stimulus(v_tenth, 1'b0);
        wait_idle();
        check_output("b2b_idle_cycles", 48'(idle_cnt - i0), 48'd2);

        // Randomized vectors with random backpressure
        $display("[TB] random");
        rdy_mode = 2;
        for (int r = 0; r < 12; r++) begin
            for (int i = 0; i < 8; i++) e[i] = 6'($urandom_range(0, 63));
            if (r % 2 == 0) begin
                for (int a = 0; a < 7; a++)
                    for (int b = 0; b < 7 - a; b++)
                        if ($signed(e[b]) < $signed(e[b+1])) begin
                            t      = e[b];
                            e[b]   = e[b+1];
                            e[b+1] = t;
                        end
            end
            apply_stimulus(pack8(e), 1'b0);
            repeat ($urandom_range(0, 3)) tick();
        end
        wait_idle();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sorted_piso.md
Name: sorted_piso

Overview:
- Parallel-in/serial-out streamer on the output side of the sort path. It is the counterpart of the serial-to-parallel collector that feeds the merge sorter.
- Captures one full 8-word result vector (y1..y8) from merge_sort in a single cycle. Emits the words one per accepted beat over a valid/ready stream, in y1..y8 order (largest first, signed).
- Sits between merge_sort outputs and any downstream serial consumer (RAM write-back, UART, etc.).

Parameters:
- WIDTH, 6, bits per element (two's-complement signed).
- DEPTH, 8, elements per vector; must be a power of two, at least 2.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- load_valid  in  1  load_data holds a complete sorted vector
- load_ready  out  1  block can accept a vector this cycle
- load_data  in  WIDTH*DEPTH  packed vector; element 0 (y1) in MSBs [WIDTH*DEPTH-1 -: WIDTH]
- out_valid  out  1  out_data holds a valid element
- out_ready  in  1  consumer accepts out_data this cycle
- out_data  out  WIDTH  current element
- out_index  out  $clog2(DEPTH)  position of out_data in the vector, 0..DEPTH-1
- out_last  out  1  high with the element at index DEPTH-1
- busy  out  1  a vector is held and not yet fully drained
- order_err  out  1  sticky ordering-violation flag (see Optional Feature)

Behaviour:
- Reset is asynchronous, active-low: all outputs and state are cleared while rst is low.
  - State = IDLE; shift register = 0.
  - load_ready = 1 once rst is high (combinational from state).
  - out_valid = 0, out_data = 0, out_index = 0, out_last = 0, busy = 0, order_err = 0.
- FSM has two states, IDLE and STREAM.
- IDLE:
  - load_ready = 1, out_valid = 0.
  - If load_valid, then on the edge: capture load_data into the shift register, set index = 0, go to STREAM.
- STREAM:
  - load_ready = 0, out_valid = 1, busy = 1.
  - out_data = shift register MSB word; out_index = index; out_last = (index == DEPTH-1).
- Beat accepted when out_valid & out_ready:
  - shift register shifts left by WIDTH, zero-filling the LSBs;
  - index increments.
  - If out_last was high, return to IDLE; index wraps to 0.
- Stall (out_valid & !out_ready): out_data, out_index and out_last stay stable, with no glitches or shifts.
- Latency:
  - Load accepted at edge k gives element 0 on out_data after edge k, i.e. visible in cycle k+1.
  - With out_ready held high, elements 0..DEPTH-1 appear in cycles k+1..k+DEPTH.
  - load_ready returns high in cycle k+DEPTH+1.
- Throughput: one vector per DEPTH+1 cycles at best. There is no overlap between load and drain.
- load_valid while in STREAM is ignored, and the data is not captured. The upstream holds load_valid until load_ready.
- out_ready while in IDLE has no effect.
- Reset mid-stream: the held vector is discarded. After release the block is in IDLE and the next load starts at index 0.
- Outputs are driven directly from registers or state; there is no combinational path from out_ready to out_valid.

Optional Feature:
- Macro: SORTED_PISO_ORDER_CHECK_EN.
- Defined:
  - On each accepted beat with index > 0, compare out_data with the previous accepted element as signed values.
  - If current > previous, set order_err on the next edge.
  - order_err is sticky and clears only on reset or on the next accepted load.
- Undefined: order_err is tied to 0 and no compare logic is built.

Decomposition:
- Shared package sort_pkg holds:
  - WIDTH_DEF = 6, DEPTH_DEF = 8, IDX_W = $clog2(DEPTH_DEF);
  - typedef elem_t (signed [WIDTH-1:0]);
  - state enum piso_state_t {IDLE, STREAM}.
- One sub-module is natural: sort_order_chk. It holds the previous-element register, the signed compare and the sticky flag, and is instantiated only under SORTED_PISO_ORDER_CHECK_EN.

Test Plan:
- Basic drain: reset, then load {31,20,7,0,-1,-5,-20,-32} (hex 1F,14,07,00,3F,3B,2C,20) with out_ready held 1.
  - Expect out_data 1F,14,07,00,3F,3B,2C,20 on consecutive cycles and out_index 0..7.
  - Expect out_last only with 20 and load_ready high again exactly one cycle later.
- Backpressure: same vector, out_ready toggles 1,0,0,1,… → each element is held stable through the stall cycles, no element is lost or duplicated, and exactly 8 handshakes occur.
- Load while busy: assert load_valid with a second vector {0x05 × 8} during STREAM → it is ignored and the first vector drains intact. The second vector is captured only after load_ready rises and is then emitted as eight 05s.
- Mid-stream reset: pull rst low after 3 accepted beats → all outputs go to 0 immediately (asynchronously). After release, loading {0x0A,0x09,…,0x03} emits from 0A with out_index 0.
- Order check (macro defined): load {10,12,8,…} → order_err rises after the beat carrying 12 and stays high through the drain. The next load clears it. With the macro undefined, order_err stays 0.
- Back-to-back vectors with out_ready held 1 and load_valid held 1 → vectors alternate with exactly one idle (out_valid = 0) cycle between them.
